// File: rtl/display_scan_controller.sv
// display_scan_controller
//   Multiplexed four-digit seven-segment scan driver. Strobes digits in the
//   order 3,2,1,0. Each digit is held for DWELL_CYCLES clocks. GAP_CYCLES blank
//   clocks follow each digit. The 16-bit BCD input is snapshotted each time
//   digit 3 is entered, so a frame never mixes old and new values.
//
//   Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits
//   (digits 3..1) of the snapshot. Digit 0 is never blanked.
//
// Ports
//   clock        : single clock, rising edge
//   reset_n      : asynchronous active-low reset
//   enable       : 1 = scan, 0 = displays off
//   digits       : four BCD digits, [15:12] = digit 3 .. [3:0] = digit 0
//   displays     : one-hot active-high digit strobe, bit n = digit n
//   segments     : active-high segments, bit0 = a .. bit6 = g
//   active_digit : index of the strobed digit (0 when none)
//   frame_done   : one-clock pulse after the last SHOW clock of digit 0
//
// State table
//   IDLE | displays off, waiting for enable
//   SHOW | strobing r_digit for DWELL_CYCLES clocks
//   GAP  | blank interval of GAP_CYCLES clocks after a digit
module display_scan_controller #(
  parameter int DWELL_CYCLES = 1000,
  parameter int GAP_CYCLES   = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] digits,
  output logic [3:0]  displays,
  output logic [6:0]  segments,
  output logic [1:0]  active_digit,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  // Counters load with interval-1 and end at zero. The 16-bit width covers both
  // parameter maxima.
  localparam logic [15:0] DWELL_LOAD = 16'(DWELL_CYCLES - 1);
  localparam logic [15:0] GAP_LOAD   = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

  state_t      r_state, w_state_nx;
  logic [1:0]  r_digit, w_digit_nx;
  logic [15:0] r_cnt, w_cnt_nx;
  logic [15:0] r_snap, w_snap_nx;
  logic        w_frame_nx;

  logic [3:0]  r_displays, w_displays_nx;
  logic [6:0]  r_segments, w_segments_nx;
  logic [1:0]  r_active, w_active_nx;
  logic        r_frame_done;

  logic [3:0]  w_nib;
  logic [6:0]  w_seg_dec;
  logic        w_blank;

  always_comb begin
    w_state_nx = r_state;
    w_digit_nx = r_digit;
    w_cnt_nx   = r_cnt;
    w_snap_nx  = r_snap;
    w_frame_nx = 1'b0;

    if (!enable) begin
      w_state_nx = IDLE;
      w_digit_nx = 2'd3;
      w_cnt_nx   = 16'd0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nx = SHOW;
          w_digit_nx = 2'd3;
          w_cnt_nx   = DWELL_LOAD;
          w_snap_nx  = digits;
        end
        SHOW: begin
          if (r_cnt == 16'd0) begin
            w_frame_nx = (r_digit == 2'd0);
            if (GAP_CYCLES > 0) begin
              w_state_nx = GAP;
              w_cnt_nx   = GAP_LOAD;
            end else begin
              // Digit index wraps 0 -> 3 naturally in two bits.
              w_digit_nx = r_digit - 2'd1;
              w_cnt_nx   = DWELL_LOAD;
              if (r_digit == 2'd0) w_snap_nx = digits;
            end
          end else begin
            w_cnt_nx = r_cnt - 16'd1;
          end
        end
        GAP: begin
          if (r_cnt == 16'd0) begin
            w_state_nx = SHOW;
            w_digit_nx = r_digit - 2'd1;
            w_cnt_nx   = DWELL_LOAD;
            if (r_digit == 2'd0) w_snap_nx = digits;
          end else begin
            w_cnt_nx = r_cnt - 16'd1;
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  // Outputs are computed from the next state and next snapshot. This lets the
  // first SHOW clock show the freshly captured value, and every output stays a
  // flop.
  always_comb begin
    w_nib = w_snap_nx[{w_digit_nx, 2'b00} +: 4];
    unique case (w_nib)
      4'd0:    w_seg_dec = 7'h3F;
      4'd1:    w_seg_dec = 7'h06;
      4'd2:    w_seg_dec = 7'h5B;
      4'd3:    w_seg_dec = 7'h4F;
      4'd4:    w_seg_dec = 7'h66;
      4'd5:    w_seg_dec = 7'h6D;
      4'd6:    w_seg_dec = 7'h7D;
      4'd7:    w_seg_dec = 7'h07;
      4'd8:    w_seg_dec = 7'h7F;
      4'd9:    w_seg_dec = 7'h6F;
      default: w_seg_dec = 7'h40;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every higher digit are zero.
  always_comb begin
    unique case (w_digit_nx)
      2'd3:    w_blank = (w_snap_nx[15:12] == 4'd0);
      2'd2:    w_blank = (w_snap_nx[15:8] == 8'd0);
      2'd1:    w_blank = (w_snap_nx[15:4] == 12'd0);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    w_displays_nx = 4'b0000;
    w_segments_nx = 7'h00;
    w_active_nx   = 2'd0;
    if (w_state_nx == SHOW) begin
      w_displays_nx = 4'b0001 << w_digit_nx;
      w_segments_nx = w_blank ? 7'h00 : w_seg_dec;
      w_active_nx   = w_digit_nx;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_digit      <= 2'd3;
      r_cnt        <= 16'd0;
      r_snap       <= 16'd0;
      r_displays   <= 4'b0000;
      r_segments   <= 7'h00;
      r_active     <= 2'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_digit      <= w_digit_nx;
      r_cnt        <= w_cnt_nx;
      r_snap       <= w_snap_nx;
      r_displays   <= w_displays_nx;
      r_segments   <= w_segments_nx;
      r_active     <= w_active_nx;
      r_frame_done <= w_frame_nx;
    end
  end

  assign displays     = r_displays;
  assign segments     = r_segments;
  assign active_digit = r_active;
  assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_display_scan_controller.sv
// Testbench for display_scan_controller. Two instances share the same stimulus:
// u0 uses DWELL=4 and GAP=1, and u1 uses DWELL=3 and GAP=0. A frame-position
// reference model pushes the expected outputs for each clock into one queue per
// instance. A monitor on the falling edge pops each queue and compares.
module tb_display_scan_controller;

  typedef struct packed {
    logic [3:0] disp;
    logic [6:0] seg;
    logic [1:0] act;
    logic       fd;
  } obs_t;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable  = 1'b0;
  logic [15:0] digits  = 16'h0000;

  logic [3:0] disp0, disp1;
  logic [6:0] seg0, seg1;
  logic [1:0] act0, act1;
  logic       fd0, fd1;

  int n_checks = 0;
  int n_bad    = 0;

  obs_t q0[$];
  obs_t q1[$];

  always #5 clock = ~clock;

  display_scan_controller #(.DWELL_CYCLES(4), .GAP_CYCLES(1)) u0 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .digits(digits),
    .displays(disp0), .segments(seg0), .active_digit(act0), .frame_done(fd0));

  display_scan_controller #(.DWELL_CYCLES(3), .GAP_CYCLES(0)) u1 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .digits(digits),
    .displays(disp1), .segments(seg1), .active_digit(act1), .frame_done(fd1));

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Expected outputs at position t of a frame. A frame has four slots of
  // (dwell + gap) clocks, and each slot shows digits 3, 2, 1, 0 in turn.
  function automatic obs_t expect_at(input int t, input int d, input int g,
                                     input logic [15:0] snap, input bit fd);
    obs_t o;
    int p, slot, off, dig;
    o    = '0;
    o.fd = fd;
    p    = d + g;
    slot = t / p;
    off  = t % p;
    if (off < d) begin
      dig    = 3 - slot;
      o.disp = 4'(1 << dig);
      o.act  = 2'(dig);
      o.seg  = seg_of(4'(snap >> (4 * dig)));
`ifdef LEADING_ZERO_BLANK_EN
      if (dig > 0 && (snap >> (4 * dig)) == 16'd0) o.seg = 7'h00;
`endif
    end
    return o;
  endfunction

  int          m_t[2];
  bit          m_run[2];
  logic [15:0] m_snap[2];
  int          cfg_d[2] = '{4, 3};
  int          cfg_g[2] = '{1, 0};

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      obs_t e;
      int   prev, len;
      bit   fd;
      len = 4 * (cfg_d[i] + cfg_g[i]);
      if (!reset_n || !enable) begin
        m_run[i] = 1'b0;
        e = '0;
      end else if (!m_run[i]) begin
        m_run[i]  = 1'b1;
        m_t[i]    = 0;
        m_snap[i] = digits;
        e = expect_at(0, cfg_d[i], cfg_g[i], m_snap[i], 1'b0);
      end else begin
        prev   = m_t[i];
        m_t[i] = (prev + 1) % len;
        if (m_t[i] == 0) m_snap[i] = digits;
        fd = (prev == 3 * (cfg_d[i] + cfg_g[i]) + cfg_d[i] - 1);
        e = expect_at(m_t[i], cfg_d[i], cfg_g[i], m_snap[i], fd);
      end
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  end

  always @(negedge clock) begin
    obs_t e, a;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      a = {disp0, seg0, act0, fd0};
      n_checks++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL u0_cycle t=%0t got disp=%b seg=%h act=%0d fd=%b want disp=%b seg=%h act=%0d fd=%b",
                 $time, a.disp, a.seg, a.act, a.fd, e.disp, e.seg, e.act, e.fd);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a = {disp1, seg1, act1, fd1};
      n_checks++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL u1_cycle t=%0t got disp=%b seg=%h act=%0d fd=%b want disp=%b seg=%h act=%0d fd=%b",
                 $time, a.disp, a.seg, a.act, a.fd, e.disp, e.seg, e.act, e.fd);
      end
    end
  end

  // Assert reset between clock edges and confirm the outputs clear without a clock.
  task automatic pulse_reset(input int low_cycles);
    obs_t a0, a1;
    @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    a0 = {disp0, seg0, act0, fd0};
    a1 = {disp1, seg1, act1, fd1};
    n_checks++;
    if (a0 !== '0 || a1 !== '0) begin
      n_bad++;
      $display("FAIL async_reset t=%0t got u0=%h u1=%h want 0", $time, a0, a1);
    end
    repeat (low_cycles) @(negedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    logic [15:0] tmp;
    int r;
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(2);

    enable = 1'b1;
    digits = 16'h1234;
    wait_cycles(6);
    digits = 16'h5678;
    wait_cycles(40);
    digits = 16'h00A7;
    wait_cycles(45);
    digits = 16'h0000;
    wait_cycles(45);
    digits = 16'h1234;
    wait_cycles(13);
    enable = 1'b0;
    wait_cycles(3);
    enable = 1'b1;
    wait_cycles(10);
    pulse_reset(2);
    wait_cycles(30);

    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        pulse_reset($urandom_range(1, 3));
      end else if (r == 1) begin
        enable = 1'b0;
        wait_cycles($urandom_range(1, 4));
        enable = 1'b1;
      end else begin
        tmp    = 16'($urandom);
        digits = tmp >> (4 * $urandom_range(0, 3));
      end
      wait_cycles($urandom_range(1, 25));
    end

    wait_cycles(3);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
